// File: rtl/hammer_hit_if.sv
// Handshake bundle between the game front end (switches, hammer, LEDs) and the
// hit detector. The master drives the player/game inputs; the slave reports the strike result.
interface hammer_hit_if #(
    parameter int NUM_POS = 5
);
    logic               enable;
    logic [NUM_POS-1:0] sw_raw;
    logic               hammer_pulse;
    logic [NUM_POS-1:0] mole_led;
    logic [NUM_POS-1:0] hit_vec;
    logic               miss_pulse;
    logic [NUM_POS-1:0] armed;
    logic               lockout;

    modport master (
        output enable, sw_raw, hammer_pulse, mole_led,
        input  hit_vec, miss_pulse, armed, lockout
    );

    modport slave (
        input  enable, sw_raw, hammer_pulse, mole_led,
        output hit_vec, miss_pulse, armed, lockout
    );
endinterface

// File: rtl/hammer_hit_detector.sv
// Arms mole positions from switch toggles under lit LEDs, then scores the next
// hammer strike as a hit vector or a miss, followed by a bounce-rejecting lockout.
module hammer_hit_detector #(
    parameter int NUM_POS       = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int LOCKOUT_TICKS = 10_000_000,
    parameter int CNT_W         = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    hammer_hit_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT_TICKS - 1);

    typedef enum logic {IDLE, LOCK} state_t;

    logic [NUM_POS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_POS-1:0] sync_d [SYNC_STAGES];
    logic [NUM_POS-1:0] sw_prev_q, sw_prev_d;
    logic [NUM_POS-1:0] led_prev_q, led_prev_d;
    logic [NUM_POS-1:0] armed_q, armed_d;
    logic [NUM_POS-1:0] hit_vec_q, hit_vec_d;
    logic               miss_pulse_q, miss_pulse_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    state_t             state_q, state_d;

    logic [NUM_POS-1:0] sw_s;
    logic [NUM_POS-1:0] sw_edge;
    logic [NUM_POS-1:0] led_rise;
    logic [NUM_POS-1:0] scored;
    logic               strike;

    // Synchroniser and history registers run regardless of enable so that
    // re-enabling never presents a stale edge.
    always_comb begin
        sync_d[0] = bus.sw_raw;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        sw_s       = sync_q[SYNC_STAGES-1];
        sw_prev_d  = sw_s;
        led_prev_d = bus.mole_led;
        sw_edge    = sw_s ^ sw_prev_q;
        led_rise   = bus.mole_led & ~led_prev_q;
    end

    always_comb begin
        strike = (state_q == IDLE) && bus.enable && bus.hammer_pulse;
        scored = armed_q & bus.mole_led;
        for (int i = 0; i < NUM_POS; i++) begin
            if (!bus.enable || strike || !bus.mole_led[i] || led_rise[i]) begin
                armed_d[i] = 1'b0;
            end else if (sw_edge[i]) begin
                armed_d[i] = 1'b1;
            end else begin
                armed_d[i] = armed_q[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hit_vec_d    = '0;
        miss_pulse_d = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (strike) begin
                        hit_vec_d    = scored;
                        miss_pulse_d = (scored == '0);
                        cnt_d        = CNT_LOAD;
                        state_d      = LOCK;
                    end
                end
                LOCK: begin
                    // The cycle that sees cnt==0 is the last lockout cycle.
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            sw_prev_q    <= '0;
            led_prev_q   <= '0;
            armed_q      <= '0;
            hit_vec_q    <= '0;
            miss_pulse_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= IDLE;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            sw_prev_q    <= sw_prev_d;
            led_prev_q   <= led_prev_d;
            armed_q      <= armed_d;
            hit_vec_q    <= hit_vec_d;
            miss_pulse_q <= miss_pulse_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
        end
    end

    assign bus.hit_vec    = hit_vec_q;
    assign bus.miss_pulse = miss_pulse_q;
    assign bus.armed      = armed_q;
    assign bus.lockout    = (state_q == LOCK);

endmodule

// File: tb/tb_hammer_hit_detector.sv
// Directed bench for hammer_hit_detector with a short lockout window.
module tb_hammer_hit_detector;

    localparam int NUM_POS = 5;
    localparam int LT      = 8;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   lock_cnt;

    hammer_hit_if #(.NUM_POS(NUM_POS)) hif ();

    hammer_hit_detector #(
        .NUM_POS(NUM_POS),
        .SYNC_STAGES(2),
        .LOCKOUT_TICKS(LT),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strike();
        hif.hammer_pulse = 1'b1;
        tick();
        hif.hammer_pulse = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        hif.enable       = 1'b1;
        hif.sw_raw       = '0;
        hif.hammer_pulse = 1'b0;
        hif.mole_led     = '0;
        tick(3);
        chk("rst_hit",   32'(hif.hit_vec), 32'h0);
        chk("rst_miss",  32'(hif.miss_pulse), 32'h0);
        chk("rst_armed", 32'(hif.armed), 32'h0);
        chk("rst_lock",  32'(hif.lockout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

        // 1: arm position 2 and score it
        hif.mole_led  = 5'b00100;
        hif.sw_raw[2] = 1'b1;
        tick(3);
        chk("t1_armed", 32'(hif.armed), 32'h04);
        tick(1);
        strike();
        chk("t1_hit",   32'(hif.hit_vec), 32'h04);
        chk("t1_miss",  32'(hif.miss_pulse), 32'h0);
        chk("t1_clr",   32'(hif.armed), 32'h0);
        lock_cnt = hif.lockout ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) chk("t1_hit_1cyc", 32'(hif.hit_vec), 32'h0);
            if (!hif.lockout) break;
            lock_cnt++;
        end
        chk("t1_lock_len", 32'(lock_cnt), 32'(LT));

        // 2: toggle under an unlit LED gives a miss
        hif.sw_raw[3] = 1'b1;
        tick(4);
        chk("t2_armed", 32'(hif.armed), 32'h0);
        strike();
        chk("t2_hit",  32'(hif.hit_vec), 32'h0);
        chk("t2_miss", 32'(hif.miss_pulse), 32'h1);
        tick();
        chk("t2_miss_1cyc", 32'(hif.miss_pulse), 32'h0);
        tick(9);

        // 3: strikes during lockout are ignored, arming continues
        hif.sw_raw[2] = 1'b0;
        tick(4);
        strike();
        chk("t3_hit0", 32'(hif.hit_vec), 32'h04);
        hif.sw_raw[2] = 1'b1;
        tick(2);
        strike();
        chk("t3_ign_hit",  32'(hif.hit_vec), 32'h0);
        chk("t3_ign_miss", 32'(hif.miss_pulse), 32'h0);
        chk("t3_armed",    32'(hif.armed), 32'h04);
        chk("t3_lock",     32'(hif.lockout), 32'h1);
        tick(5);
        chk("t3_lock_end", 32'(hif.lockout), 32'h0);
        strike();
        chk("t3_hit1", 32'(hif.hit_vec), 32'h04);
        chk("t3_miss1", 32'(hif.miss_pulse), 32'h0);
        tick(9);

        // 4: edge coincident with LED rise does not arm
        hif.mole_led = 5'b00000;
        tick(2);
        hif.sw_raw[1] = 1'b1;
        tick(2);
        hif.mole_led = 5'b00010;
        tick();
        chk("t4_armed", 32'(hif.armed), 32'h0);
        tick(2);
        strike();
        chk("t4_hit",  32'(hif.hit_vec), 32'h0);
        chk("t4_miss", 32'(hif.miss_pulse), 32'h1);
        tick(9);

        // 5: enable drop flushes armed and lockout
        hif.mole_led = 5'b00001;
        tick();
        strike();
        chk("t5_miss", 32'(hif.miss_pulse), 32'h1);
        hif.sw_raw[0] = 1'b1;
        tick(3);
        chk("t5_armed", 32'(hif.armed), 32'h01);
        chk("t5_lock",  32'(hif.lockout), 32'h1);
        hif.enable = 1'b0;
        tick();
        chk("t5_dis_armed", 32'(hif.armed), 32'h0);
        chk("t5_dis_lock",  32'(hif.lockout), 32'h0);
        strike();
        chk("t5_dis_miss", 32'(hif.miss_pulse), 32'h0);
        chk("t5_dis_lock2", 32'(hif.lockout), 32'h0);
        hif.sw_raw[0] = 1'b0;
        tick(4);
        hif.enable = 1'b1;
        tick(4);
        chk("t5_no_spur", 32'(hif.armed), 32'h0);
        hif.enable       = 1'b0;
        hif.hammer_pulse = 1'b1;
        tick();
        hif.hammer_pulse = 1'b0;
        hif.enable       = 1'b1;
        chk("t5_fall_miss", 32'(hif.miss_pulse), 32'h0);
        chk("t5_fall_lock", 32'(hif.lockout), 32'h0);
        tick(2);

        // 6: asynchronous reset mid-lockout
        strike();
        chk("t6_miss", 32'(hif.miss_pulse), 32'h1);
        chk("t6_lock", 32'(hif.lockout), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_miss", 32'(hif.miss_pulse), 32'h0);
        chk("t6_rst_lock", 32'(hif.lockout), 32'h0);
        chk("t6_rst_hit",  32'(hif.hit_vec), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_post_miss", 32'(hif.miss_pulse), 32'h0);
        chk("t6_post_lock", 32'(hif.lockout), 32'h0);
        tick(4);
        chk("t6_post_armed", 32'(hif.armed), 32'h0);
        chk("t6_post_hit",   32'(hif.hit_vec), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
